// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and the VGA frame-buffer reader.
// CPU has priority; VGA is forced ahead after MAX_WAIT consecutive refused cycles.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0]           wait_q, wait_d;
  logic [RD_LAT-1:0][1:0]  tag_q, tag_d;   // {cpu_rd, vga_rd} per latency stage
  logic [15:0]             stall_cnt_q, stall_cnt_d;
  logic                    force_vga;

  always_comb begin
    force_vga = vga_req & (wait_q == WW'(MAX_WAIT));
    cpu_gnt   = 1'b0;
    vga_gnt   = 1'b0;
    // Grants are suppressed during reset so nothing reaches memory.
    if (rst_n) begin
      if (force_vga)    vga_gnt = 1'b1;
      else if (cpu_req) cpu_gnt = 1'b1;
      else if (vga_req) vga_gnt = 1'b1;
    end

    mem_addr  = vga_gnt ? vga_addr : cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_gnt & cpu_we;
    stall     = rst_n & cpu_req & ~cpu_gnt;

    wait_d = wait_q;
    if (vga_gnt || !vga_req)            wait_d = '0;
    else if (wait_q != WW'(MAX_WAIT))   wait_d = wait_q + WW'(1);

    tag_d    = tag_q;
    tag_d[0] = {cpu_gnt & ~cpu_we, vga_gnt};
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q      <= '0;
      tag_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      wait_q      <= wait_d;
      tag_q       <= tag_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cpu_rvalid = rst_n & tag_q[RD_LAT-1][1];
  assign vga_rvalid = rst_n & tag_q[RD_LAT-1][0];
  assign cpu_rdata  = mem_rdata;
  assign vga_rdata  = mem_rdata;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, CPU write/read, VGA streaming,
// starvation guard, reset mid-read and stall counter saturation.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic        vga_gnt, vga_rvalid;
  logic [31:0] vga_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .stall(stall),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .vga_rdata(vga_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // Synchronous memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic rn, input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic vr, input logic [31:0] va);
    @(negedge clk);
    rst_n = rn; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    vga_req = vr; vga_addr = va;
    #1;
    chk("one_gnt", 32'(cpu_gnt & vga_gnt), 32'd0);
    chk("one_rvalid", 32'(cpu_rvalid & vga_rvalid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int k = 0; k < 4; k++) mem[10'h100 + k] = 32'hA0A0_0000 + k;
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    vga_req = 1'b1; vga_addr = 32'h0;

    // Reset held two cycles with both requests asserted.
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_vga_gnt", 32'(vga_gnt), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
    end
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // First cycle after release: CPU write wins.
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", mem_addr, 32'h10);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("idle_gnt", 32'({cpu_gnt, vga_gnt}), 32'd0);
    chk("idle_mem_we", 32'(mem_we), 32'd0);

    // VGA streaming with an idle CPU.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, k < 4, 32'h100 + k);
      chk("vga_gnt", 32'(vga_gnt), 32'(k < 4));
      if (k < 4) chk("vga_mem_addr", mem_addr, 32'h100 + k);
      chk("vga_rvalid", 32'(vga_rvalid), 32'(k > 0));
      if (k > 0) chk("vga_rdata", vga_rdata, 32'hA0A0_0000 + k - 1);
      chk("vga_no_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    end

    // Starvation guard: both requests held, VGA forced every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h200);
      chk("starve_cpu_gnt", 32'(cpu_gnt), 32'(i % 5 != 4));
      chk("starve_vga_gnt", 32'(vga_gnt), 32'(i % 5 == 4));
      chk("starve_stall", 32'(stall), 32'(i % 5 == 4));
      chk("starve_cpu_rvalid", 32'(cpu_rvalid), 32'(i > 0 && (i - 1) % 5 != 4));
      chk("starve_vga_rvalid", 32'(vga_rvalid), 32'(i > 0 && (i - 1) % 5 == 4));
      chk("starve_stall_cnt", 32'(stall_cnt), 32'(i / 5));
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("starve_stall_cnt_end", 32'(stall_cnt), 32'd2);

    // Reset arriving while a CPU read is in flight.
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("mid_cpu_gnt", 32'(cpu_gnt), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("mid_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("mid_post_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("mid_stall_cnt", 32'(stall_cnt), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("mid_post_rvalid2", 32'(cpu_rvalid), 32'd0);

    // Saturation: preload near the top, then three more stall cycles.
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFD;
    #1 release dut.stall_cnt_q;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h200);
      if (i == 5)  chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
      if (i == 10) chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
      if (i == 15) chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
